// File: rtl/mem_access_unit.sv
// Load/store sequencer for a single-cycle byte-addressable 32-bit memory:
// sizing, sign/zero extension, read-modify-write sub-word stores, alignment check, dump strobe.
module mem_access_unit #(
  parameter int ADDR_W      = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic              dump_req,
  output logic              dump_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_createdump
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4,
    DUMP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Goes high on the first edge after reset release so req_ready stays low while rst_n is low.
  logic run_q;

  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_misaligned;
  logic              accept;
  logic [31:0]       load_ext;
  logic [31:0]       merge_val;

  // NOTE: every always_comb assigns defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    req_misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      unique case (req_size)
        2'b00:   req_misaligned = 1'b0;
        2'b01:   req_misaligned = req_addr[0];
        default: req_misaligned = |req_addr[1:0];
      endcase
    end
  end

  assign accept = run_q && (state_q == IDLE) && req_valid;

  // Extract the addressed byte/half from the little-endian read word and extend it.
  always_comb begin
    load_ext  = mem_data_out;
    merge_val = mem_data_out;
    unique case (size_q)
      2'b00: begin
        load_ext  = {{24{~uns_q & mem_data_out[7]}}, mem_data_out[7:0]};
        merge_val = {mem_data_out[31:8], wdata_q[7:0]};
      end
      2'b01: begin
        load_ext  = {{16{~uns_q & mem_data_out[15]}}, mem_data_out[15:0]};
        merge_val = {mem_data_out[31:16], wdata_q[15:0]};
      end
      default: begin
        load_ext  = mem_data_out;
        merge_val = wdata_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_misaligned)   state_d = RESP;
          else if (!req_wr)     state_d = LOAD;
          else if (req_size[1]) state_d = WRITE;
          else                  state_d = RMW_RD;
        end else if (run_q && dump_req) begin
          state_d = DUMP;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      DUMP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        merge_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= req_misaligned;
      end
      if (state_q == LOAD)   rdata_q <= load_ext;
      if (state_q == RMW_RD) merge_q <= merge_val;
    end
  end

  // Outputs decode registered state only; nothing from req_* reaches mem_*.
  always_comb begin
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    dump_ack       = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    mem_createdump = 1'b0;
    unique case (state_q)
      IDLE: req_ready = run_q;
      LOAD, RMW_RD: begin
        mem_enable = 1'b1;
        mem_addr   = addr_q;
      end
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = addr_q;
        mem_data_in = merge_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      DUMP: begin
        mem_createdump = 1'b1;
        dump_ack       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory model, directed vector table,
// multi-cycle corner sequences and randomized traffic against a byte-level reference model.
module tb_mem_access_unit;

  localparam bit CHECK_ALIGN = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        dump_req, dump_ack;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr;
  logic [31:0] mem_data_in, mem_data_out;

  mem_access_unit #(.ADDR_W(16), .CHECK_ALIGN(CHECK_ALIGN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dump_req(dump_req), .dump_ack(dump_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_createdump(mem_createdump)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to: little-endian, 4-byte access, wrapping addresses.
  logic [7:0]  mem [65536] = '{default: 8'h00};
  logic [15:0] a1, a2, a3;
  assign a1 = mem_addr + 16'd1;
  assign a2 = mem_addr + 16'd2;
  assign a3 = mem_addr + 16'd3;
  assign mem_data_out = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem[mem_addr] <= mem_data_in[7:0];
      mem[a1]       <= mem_data_in[15:8];
      mem[a2]       <= mem_data_in[23:16];
      mem[a3]       <= mem_data_in[31:24];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Protocol monitor.
  int viol = 0, en_cnt = 0, dump_cnt = 0;
  always @(negedge clk) begin
    if (mem_enable) en_cnt++;
    if (mem_createdump) dump_cnt++;
    if (!mem_enable && (mem_wr || mem_addr != 16'h0 || mem_data_in != 32'h0)) viol++;
    if (mem_createdump && (mem_enable || !dump_ack)) viol++;
    if (dump_ack && !mem_createdump) viol++;
    if (rsp_valid && req_ready) viol++;
  end

  // Reference model: a plain byte array updated with the architectural effect of each request.
  logic [7:0] ref_mem [65536] = '{default: 8'h00};

  task automatic ref_apply(input logic wr, input logic [1:0] size, input logic uns,
                           input logic [15:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
    int nbytes;
    logic [31:0] v;
    logic [15:0] a;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    v = 32'h0;
    rdata = 32'h0;
    err = CHECK_ALIGN && ((int'(addr) % nbytes) != 0);
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      lat = 2;
      for (int k = 0; k < nbytes; k++) begin
        a = addr + 16'(k);
        v = v | (32'(ref_mem[a]) << (8 * k));
      end
      if (!uns && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      rdata = v;
    end else begin
      lat = (nbytes == 4) ? 2 : 3;
      for (int k = 0; k < nbytes; k++) begin
        a = addr + 16'(k);
        ref_mem[a] = wdata[8*k +: 8];
      end
    end
  endtask

  // One full request/response handshake; called and returns just after a falling edge.
  task automatic transact(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_err", 32'(rsp_err), 32'(err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("release_idle", {30'h0, req_ready, rsp_valid}, 32'h2);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd, word;
    logic        er, exp_er;
    int          lat, exp_lat, e0, d0, mem_bad, hold;
    logic        r_wr, r_uns;
    logic [1:0]  r_size;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;

    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b0; dump_req = 1'b0;

    // Stores with expected rdata 0; sub-word stores take 3 cycles, word ops 2, errors 1.
    tbl.push_back('{1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 16'h0010, 32'h123456A5, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEA5, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 16'h0010, 32'h0,        32'hFFFFFFA5, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 16'h0010, 32'h0,        32'h000000A5, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 16'h0013, 32'h0000FFFF, 32'h00000000, 1'b1, 1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEA5, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 16'h0012, 32'h55558001, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'h8001BEA5, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 16'h0012, 32'h0,        32'hFFFF8001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b1, 16'h0012, 32'h0,        32'h00008001, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd3, 1'b0, 16'h0010, 32'h0,        32'h8001BEA5, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 16'h0011, 32'h0,        32'h00000000, 1'b1, 1});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0012, 32'h0,        32'h00000000, 1'b1, 1});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 16'h0011, 32'h0,        32'hFFFFFFBE, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b0, 16'h0013, 32'h0,        32'hFFFFFF80, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd3, 1'b0, 16'h0030, 32'h0BADF00D, 32'h00000000, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b1, 16'h0030, 32'h0,        32'h0BADF00D, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd2, 1'b0, 16'h0000, 32'hCAFEF00D, 32'h00000000, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd0, 1'b0, 16'hFFFF, 32'h0000005A, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'h0000, 32'h0,        32'hCAFEF00D, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd0, 1'b1, 16'hFFFF, 32'h0,        32'h0000005A, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0,        32'h5A000000, 1'b0, 2});
    tbl.push_back('{1'b1, 2'd1, 1'b0, 16'hFFFE, 32'hAAAA7F01, 32'h00000000, 1'b0, 3});
    tbl.push_back('{1'b0, 2'd1, 1'b0, 16'hFFFE, 32'h0,        32'h00007F01, 1'b0, 2});
    tbl.push_back('{1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0,        32'h7F010000, 1'b0, 2});

    // Reset state: every output low while rst_n is asserted.
    #1;
    check("reset_ctrl", {25'h0, req_ready, rsp_valid, rsp_err, dump_ack, mem_enable, mem_wr,
                         mem_createdump}, 32'h0);
    check("reset_data", rsp_rdata | mem_data_in | 32'(mem_addr), 32'h0);
    #16 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;

    foreach (tbl[i]) begin
      e0 = en_cnt;
      ref_apply(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, exp_rd, exp_er, exp_lat);
      transact(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (tbl[i].exp_err) check($sformatf("vec%0d_no_mem_access", i), 32'(en_cnt), 32'(e0));
    end

    // Load response held off for 5 cycles.
    transact(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 5, rd, er, lat);
    check("stall_rdata", rd, 32'h8001BEA5);

    // Reset during the read half of a byte store.
    ref_apply(1'b1, 2'd2, 1'b0, 16'h0020, 32'h12345678, exp_rd, exp_er, exp_lat);
    transact(1'b1, 2'd2, 1'b0, 16'h0020, 32'h12345678, 0, rd, er, lat);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 16'h0020; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw_rd_active", {30'h0, mem_enable, mem_wr}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("midop_reset_ctrl", {25'h0, req_ready, rsp_valid, rsp_err, dump_ack, mem_enable, mem_wr,
                               mem_createdump}, 32'h0);
    check("midop_reset_addr", 32'(mem_addr), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    word = {mem[16'h0023], mem[16'h0022], mem[16'h0021], mem[16'h0020]};
    check("midop_reset_no_write", word, 32'h12345678);
    @(posedge clk);
    #1 check("ready_after_reset", 32'(req_ready), 32'd1);
    @(negedge clk);
    #1;
    transact(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 0, rd, er, lat);
    check("midop_reset_reload", rd, 32'h12345678);

    // Request and dump_req together: request first, then a single dump pulse.
    d0 = dump_cnt;
    dump_req = 1'b1;
    transact(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 0, rd, er, lat);
    check("dump_req_rdata", rd, 32'h8001BEA5);
    check("dump_req_latency", 32'(lat), 32'd2);
    check("dump_not_before_req", 32'(dump_cnt), 32'(d0));
    @(posedge clk);
    #1 check("dump_pulse", {29'h0, mem_createdump, dump_ack, mem_enable}, 32'h6);
    dump_req = 1'b0;
    @(posedge clk);
    #1 check("dump_single_cycle", {30'h0, mem_createdump, dump_ack}, 32'h0);
    dump_req = 1'b1;
    @(posedge clk);
    #1 check("dump_retrigger", {30'h0, mem_createdump, dump_ack}, 32'h3);
    dump_req = 1'b0;
    @(posedge clk);
    #1 check("dump_count", 32'(dump_cnt), 32'(d0 + 2));
    @(negedge clk);
    #1;

    // Randomized traffic concentrated on two small windows, one of them wrapping.
    for (int i = 0; i < 300; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63))
                                            : 16'(16'hFFF0 + 16'($urandom_range(0, 15)));
      r_wdata = $urandom;
      hold    = $urandom_range(0, 2);
      ref_apply(r_wr, r_size, r_uns, r_addr, r_wdata, exp_rd, exp_er, exp_lat);
      transact(r_wr, r_size, r_uns, r_addr, r_wdata, hold, rd, er, lat);
      check($sformatf("rand%0d_rdata", i), rd, exp_rd);
      check($sformatf("rand%0d_err", i), 32'(er), 32'(exp_er));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    mem_bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) mem_bad++;
    check("memory_image", 32'(mem_bad), 32'd0);
    check("protocol_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
